// File: rtl/histogram_equalization_mc.sv
// Per-channel histogram equalization. Each frame builds a histogram. The CDF of that histogram
// becomes a shadow LUT, which is swapped into the active LUT between frames.
module histogram_equalization_mc #(
  parameter int NB_IMG_CHNL = 1,
  parameter int WD_IMG_DATA = 8,
  parameter int NB_IMG_HORI = 960,
  parameter int NB_IMG_VERT = 640,
  parameter int WD_ERR_INFO = 4
) (
  input  logic                                 i_sys_clk,
  input  logic                                 i_sys_reset,
  input  logic                                 i_cfg_bypass,
  input  logic                                 s_img_c_fsync,
  input  logic                                 s_img_c_vsync,
  input  logic                                 s_img_c_hsync,
  input  logic [NB_IMG_CHNL*WD_IMG_DATA-1:0]   s_img_y_mdat,
  output logic                                 m_img_c_fsync,
  output logic                                 m_img_c_vsync,
  output logic                                 m_img_c_hsync,
  output logic [NB_IMG_CHNL*WD_IMG_DATA-1:0]   m_img_y_mdat,
  output logic                                 m_lut_valid,
  output logic [WD_ERR_INFO-1:0]               m_err_histogram_info
);
  localparam int NB_BIN = 1 << WD_IMG_DATA;
  localparam int NB_PIX = NB_IMG_HORI * NB_IMG_VERT;
  localparam int WD_CNT = $clog2(NB_PIX + 1);
  localparam int WD_PRD = WD_CNT + 32;
  localparam logic [31:0] C_GAIN = 32'(((64'(NB_BIN) - 64'd1) << 24) / 64'(NB_PIX));

  typedef enum logic [1:0] {ST_IDLE, ST_ACCU, ST_CALC, ST_SWAP} state_e;

  state_e                 state_q;
  logic                   fsync_prev_q;
  logic                   fsync_q, vsync_q, hsync_q;
  logic [WD_IMG_DATA-1:0] bin_q;
  logic [WD_CNT:0]        pix_cnt_q, pix_cnt_d;
  logic                   lut_valid_q;
  logic [2:0]             err_q;
  logic                   fsync_rise, fsync_fall, accept;

  assign fsync_rise = s_img_c_fsync & ~fsync_prev_q;
  assign fsync_fall = ~s_img_c_fsync & fsync_prev_q;
  assign accept     = (state_q == ST_ACCU) && s_img_c_hsync && s_img_c_vsync;

  // The pixel counter is one bit wider than needed and saturates, so surplus pixels are never
  // hidden by wrap-around.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (accept && (pix_cnt_q != '1)) pix_cnt_d = pix_cnt_q + (WD_CNT+1)'(1);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_reset) begin
      state_q      <= ST_IDLE;
      fsync_prev_q <= 1'b0;
      fsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      bin_q        <= '0;
      pix_cnt_q    <= '0;
      lut_valid_q  <= 1'b0;
      err_q        <= '0;
    end else begin
      fsync_prev_q <= s_img_c_fsync;
      fsync_q      <= s_img_c_fsync;
      vsync_q      <= s_img_c_vsync;
      hsync_q      <= s_img_c_hsync;
      if (s_img_c_hsync && !s_img_c_vsync) err_q[2] <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (fsync_rise) begin
            state_q   <= ST_ACCU;
            pix_cnt_q <= '0;
          end
        end
        ST_ACCU: begin
          pix_cnt_q <= pix_cnt_d;
          if (fsync_fall) begin
            state_q <= ST_CALC;
            bin_q   <= '0;
            if (pix_cnt_d != (WD_CNT+1)'(NB_PIX)) err_q[1] <= 1'b1;
          end
        end
        ST_CALC: begin
          if (fsync_rise) err_q[0] <= 1'b1;
          bin_q <= bin_q + WD_IMG_DATA'(1);
          if (bin_q == WD_IMG_DATA'(NB_BIN - 1)) state_q <= ST_SWAP;
        end
        default: begin
          if (fsync_rise) err_q[0] <= 1'b1;
          lut_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NB_IMG_CHNL; gi++) begin : g_chnl
    logic [WD_CNT-1:0]      hist_q   [NB_BIN];
    logic [WD_IMG_DATA-1:0] shadow_q [NB_BIN];
    logic [WD_IMG_DATA-1:0] active_q [NB_BIN];
    logic [WD_CNT-1:0]      cdf_q, cdf_d;
    logic [WD_PRD-1:0]      scaled;
    logic [WD_IMG_DATA-1:0] lut_d, pix, mdat_q;

    assign pix = s_img_y_mdat[gi*WD_IMG_DATA +: WD_IMG_DATA];
    assign m_img_y_mdat[gi*WD_IMG_DATA +: WD_IMG_DATA] = mdat_q;

    // Inclusive CDF scaled by a fixed-point gain. The 24-bit fraction is dropped and the result
    // is clamped to the top bin.
    always_comb begin
      cdf_d  = cdf_q + hist_q[bin_q];
      scaled = (WD_PRD'(cdf_d) * WD_PRD'(C_GAIN)) >> 24;
      lut_d  = (scaled > WD_PRD'(NB_BIN - 1)) ? WD_IMG_DATA'(NB_BIN - 1)
                                              : scaled[WD_IMG_DATA-1:0];
    end

    always_ff @(posedge i_sys_clk) begin
      if (i_sys_reset) begin
        for (int b = 0; b < NB_BIN; b++) begin
          hist_q[b]   <= '0;
          shadow_q[b] <= '0;
          active_q[b] <= '0;
        end
        cdf_q  <= '0;
        mdat_q <= '0;
      end else begin
        if (accept && (hist_q[pix] != '1)) hist_q[pix] <= hist_q[pix] + WD_CNT'(1);
        if (state_q == ST_CALC) begin
          cdf_q           <= cdf_d;
          shadow_q[bin_q] <= lut_d;
          hist_q[bin_q]   <= '0;
        end
        if (state_q == ST_SWAP) begin
          for (int b = 0; b < NB_BIN; b++) active_q[b] <= shadow_q[b];
          cdf_q <= '0;
        end
        if (s_img_c_hsync) mdat_q <= (lut_valid_q && !i_cfg_bypass) ? active_q[pix] : pix;
      end
    end
  end

  assign m_img_c_fsync        = fsync_q;
  assign m_img_c_vsync        = vsync_q;
  assign m_img_c_hsync        = hsync_q;
  assign m_lut_valid          = lut_valid_q;
  assign m_err_histogram_info = WD_ERR_INFO'(err_q);

endmodule

// File: tb/tb_histogram_equalization_mc.sv
// Directed bench for histogram_equalization_mc. It drives a 1-channel and a 2-channel instance of
// the 3-bit, 4x2 image configuration.
module tb_histogram_equalization_mc;
  logic clk = 1'b0, rst = 1'b1, bypass = 1'b0;
  logic s_fsync = 1'b0, s_vsync = 1'b0, s_hsync = 1'b0;
  logic [5:0] s_mdat = '0;
  logic a_fsync, a_vsync, a_hsync, a_valid;
  logic [2:0] a_mdat;
  logic [3:0] a_err;
  logic b_fsync, b_vsync, b_hsync, b_valid;
  logic [5:0] b_mdat;
  logic [3:0] b_err;
  int n_tests = 0, n_fail = 0;
  logic [5:0] frame_pix [8];
  logic [2:0] cap_a [8];
  logic [5:0] cap_b [8];
  logic [2:0] exp_a [8];

  always #5 clk = ~clk;

  histogram_equalization_mc #(.NB_IMG_CHNL(1), .WD_IMG_DATA(3), .NB_IMG_HORI(4),
                              .NB_IMG_VERT(2), .WD_ERR_INFO(4)) dut_a (
    .i_sys_clk(clk), .i_sys_reset(rst), .i_cfg_bypass(bypass),
    .s_img_c_fsync(s_fsync), .s_img_c_vsync(s_vsync), .s_img_c_hsync(s_hsync),
    .s_img_y_mdat(s_mdat[2:0]),
    .m_img_c_fsync(a_fsync), .m_img_c_vsync(a_vsync), .m_img_c_hsync(a_hsync),
    .m_img_y_mdat(a_mdat), .m_lut_valid(a_valid), .m_err_histogram_info(a_err));

  histogram_equalization_mc #(.NB_IMG_CHNL(2), .WD_IMG_DATA(3), .NB_IMG_HORI(4),
                              .NB_IMG_VERT(2), .WD_ERR_INFO(4)) dut_b (
    .i_sys_clk(clk), .i_sys_reset(rst), .i_cfg_bypass(bypass),
    .s_img_c_fsync(s_fsync), .s_img_c_vsync(s_vsync), .s_img_c_hsync(s_hsync),
    .s_img_y_mdat(s_mdat),
    .m_img_c_fsync(b_fsync), .m_img_c_vsync(b_vsync), .m_img_c_hsync(b_hsync),
    .m_img_y_mdat(b_mdat), .m_lut_valid(b_valid), .m_err_histogram_info(b_err));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one 8-pixel frame and captures each registered output right after its pixel's edge.
  // The optional glitch cycle has hsync high while vsync is low.
  task automatic drive_frame(input int nvalid, input int tail, input bit glitch);
    s_fsync = 1'b1;
    step();
    if (glitch) begin
      s_vsync = 1'b0; s_hsync = 1'b1; s_mdat = '0;
      step();
    end
    for (int i = 0; i < 8; i++) begin
      s_vsync = 1'b1; s_hsync = (i < nvalid); s_mdat = frame_pix[i];
      step();
      cap_a[i] = a_mdat;
      cap_b[i] = b_mdat;
    end
    s_vsync = 1'b0; s_hsync = 1'b0; s_fsync = 1'b0;
    repeat (tail) step();
    $display("[TB] frame: %0d valid pixels, glitch=%0d", nvalid, glitch);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_fsync = 1'b1; s_vsync = 1'b1; s_hsync = 1'b1; s_mdat = 6'h2d;
    step(); step();
    n_tests++; if (a_mdat !== 3'd0) begin $display("FAIL reset_mdat: got %0d expected 0", a_mdat); n_fail++; end
    n_tests++; if (a_fsync !== 1'b0) begin $display("FAIL reset_fsync: got %0b expected 0", a_fsync); n_fail++; end
    n_tests++; if (a_vsync !== 1'b0) begin $display("FAIL reset_vsync: got %0b expected 0", a_vsync); n_fail++; end
    n_tests++; if (a_hsync !== 1'b0) begin $display("FAIL reset_hsync: got %0b expected 0", a_hsync); n_fail++; end
    n_tests++; if (a_valid !== 1'b0) begin $display("FAIL reset_valid: got %0b expected 0", a_valid); n_fail++; end
    n_tests++; if (a_err !== 4'd0) begin $display("FAIL reset_err: got %0h expected 0", a_err); n_fail++; end
    n_tests++;
    if ({b_fsync, b_vsync, b_hsync, b_mdat} !== 9'd0) begin
      $display("FAIL reset_b_outputs: got %0h expected 0", {b_fsync, b_vsync, b_hsync, b_mdat});
      n_fail++;
    end
    rst = 1'b0; s_fsync = 1'b0; s_vsync = 1'b0; s_hsync = 1'b0; s_mdat = '0;
    step();
  endtask

  task automatic test_first_frame();
    frame_pix = '{default: 6'd5};
    drive_frame(8, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== 3'd5) begin $display("FAIL first_pix%0d: got %0d expected 5", i, cap_a[i]); n_fail++; end
    end
    n_tests++;
    if ({a_fsync, a_vsync, a_hsync} !== 3'b111) begin
      $display("FAIL strobe_delay: got %b expected 111", {a_fsync, a_vsync, a_hsync});
      n_fail++;
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) begin
        n_tests++;
        if (a_hsync !== 1'b0) begin $display("FAIL strobe_drop: got %0b expected 0", a_hsync); n_fail++; end
      end
      if (i == 9) begin
        n_tests++;
        if (a_valid !== 1'b0) begin $display("FAIL lut_valid_early: got %0b expected 0", a_valid); n_fail++; end
      end
      if (i == 10) begin
        n_tests++;
        if (a_valid !== 1'b1) begin $display("FAIL lut_valid_at10: got %0b expected 1", a_valid); n_fail++; end
      end
    end
    repeat (3) step();
    frame_pix = '{6'd5, 6'd0, 6'd5, 6'd0, 6'd5, 6'd0, 6'd5, 6'd0};
    exp_a = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL second_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
    n_tests++; if (a_err !== 4'd0) begin $display("FAIL clean_err: got %0h expected 0", a_err); n_fail++; end
  endtask

  task automatic test_ramp();
    frame_pix = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
    exp_a = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd7, 3'd7, 3'd7};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL ramp_in_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
    frame_pix = '{6'd0, 6'd3, 6'd7, 6'd3, 6'd1, 6'd2, 6'd6, 6'd4};
    exp_a = '{3'd0, 3'd3, 3'd7, 3'd3, 3'd1, 3'd2, 3'd6, 3'd4};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL ramp_lut_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
    n_tests++; if (a_mdat !== 3'd4) begin $display("FAIL hold_mdat: got %0d expected 4", a_mdat); n_fail++; end
  endtask

  task automatic test_bypass();
    bypass = 1'b1;
    frame_pix = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd3, 6'd4, 6'd5, 6'd6};
    exp_a = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd3, 3'd4, 3'd5, 3'd6};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL bypass_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
    bypass = 1'b0;
    frame_pix = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd0, 6'd1, 6'd2, 6'd7};
    exp_a = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd7};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL after_bypass_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
  endtask

  task automatic test_short_frame();
    frame_pix = '{default: 6'd2};
    drive_frame(7, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== 3'd2) begin $display("FAIL short_pix%0d: got %0d expected 2", i, cap_a[i]); n_fail++; end
    end
    n_tests++; if (a_err !== 4'b0010) begin $display("FAIL short_err: got %b expected 0010", a_err); n_fail++; end
    frame_pix = '{6'd0, 6'd1, 6'd2, 6'd7, 6'd0, 6'd1, 6'd2, 6'd7};
    exp_a = '{3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 3'd6, 3'd6};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL short_lut_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
    n_tests++; if (a_err !== 4'b0010) begin $display("FAIL short_err_sticky: got %b expected 0010", a_err); n_fail++; end
  endtask

  task automatic test_fsync_in_calc();
    do_reset();
    frame_pix = '{default: 6'd5};
    drive_frame(8, 0, 1'b0);
    repeat (3) step();
    s_fsync = 1'b1;
    step();
    s_fsync = 1'b0;
    repeat (12) step();
    n_tests++; if (a_err !== 4'b0001) begin $display("FAIL calc_fsync_err: got %b expected 0001", a_err); n_fail++; end
    n_tests++; if (a_valid !== 1'b1) begin $display("FAIL calc_fsync_valid: got %0b expected 1", a_valid); n_fail++; end
    frame_pix = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
    exp_a = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL calc_next_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== frame_pix[i][2:0]) begin $display("FAIL calc_accu_pix%0d: got %0d expected %0d", i, cap_a[i], frame_pix[i][2:0]); n_fail++; end
    end
    n_tests++; if (a_err !== 4'b0001) begin $display("FAIL calc_err_final: got %b expected 0001", a_err); n_fail++; end
  endtask

  task automatic test_reset_mid_calc();
    frame_pix = '{default: 6'd5};
    drive_frame(8, 0, 1'b0);
    repeat (4) step();
    rst = 1'b1; s_fsync = 1'b1; s_vsync = 1'b1; s_hsync = 1'b1; s_mdat = 6'd3;
    step();
    n_tests++;
    if ({a_fsync, a_vsync, a_hsync, a_mdat} !== 6'd0) begin
      $display("FAIL midcalc_outputs: got %0h expected 0", {a_fsync, a_vsync, a_hsync, a_mdat});
      n_fail++;
    end
    n_tests++; if (a_valid !== 1'b0) begin $display("FAIL midcalc_valid: got %0b expected 0", a_valid); n_fail++; end
    n_tests++; if (a_err !== 4'd0) begin $display("FAIL midcalc_err: got %h expected 0", a_err); n_fail++; end
    rst = 1'b0; s_fsync = 1'b0; s_vsync = 1'b0; s_hsync = 1'b0; s_mdat = '0;
    step();
    frame_pix = '{6'd5, 6'd0, 6'd3, 6'd6, 6'd5, 6'd0, 6'd3, 6'd6};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== frame_pix[i][2:0]) begin $display("FAIL postreset_pix%0d: got %0d expected %0d", i, cap_a[i], frame_pix[i][2:0]); n_fail++; end
    end
    frame_pix = '{6'd0, 6'd3, 6'd5, 6'd6, 6'd1, 6'd2, 6'd4, 6'd7};
    exp_a = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd1, 3'd1, 3'd3, 3'd7};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL clean_accu_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
  endtask

  task automatic test_hsync_no_vsync();
    frame_pix = '{default: 6'd1};
    drive_frame(8, 12, 1'b1);
    n_tests++; if (a_err !== 4'b0100) begin $display("FAIL glitch_err: got %b expected 0100", a_err); n_fail++; end
    frame_pix = '{6'd0, 6'd1, 6'd7, 6'd1, 6'd0, 6'd1, 6'd7, 6'd1};
    exp_a = '{3'd0, 3'd7, 3'd7, 3'd7, 3'd0, 3'd7, 3'd7, 3'd7};
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_a[i] !== exp_a[i]) begin $display("FAIL glitch_lut_pix%0d: got %0d expected %0d", i, cap_a[i], exp_a[i]); n_fail++; end
    end
  endtask

  task automatic test_two_chnl();
    do_reset();
    frame_pix = '{default: 6'b010_101};
    drive_frame(8, 12, 1'b0);
    n_tests++; if (b_valid !== 1'b1) begin $display("FAIL two_chnl_valid: got %0b expected 1", b_valid); n_fail++; end
    n_tests++; if (b_err !== 4'd0) begin $display("FAIL two_chnl_err: got %b expected 0", b_err); n_fail++; end
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_b[i] !== 6'b111_111) begin $display("FAIL two_chnl_pix%0d: got %o expected 77", i, cap_b[i]); n_fail++; end
    end
    bypass = 1'b1;
    drive_frame(8, 12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_b[i] !== 6'b010_101) begin $display("FAIL two_chnl_bypass_pix%0d: got %o expected 25", i, cap_b[i]); n_fail++; end
    end
    bypass = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_ramp();
    test_bypass();
    test_short_frame();
    test_fsync_in_calc();
    test_reset_mid_calc();
    test_hsync_no_vsync();
    test_two_chnl();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
